// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one 64-bit adder between two requesters.
// The result lands in a single-entry output buffer that has valid/ready backpressure.

module adder_64bit (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        c_in,
   output logic [63:0] sum,
   output logic        ovf
);
   assign sum = a + b + {63'd0, c_in};
   // Signed overflow: the operands share a sign and the result's sign differs from it.
   assign ovf = (a[63] == b[63]) && (sum[63] != a[63]);
endmodule

module adder_share_arbiter #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_ovf,
   output logic             res_id,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_reg, state_next;
   logic             rr_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             ovf_reg;
   logic             id_reg;
   logic [CNT_W-1:0] cnt0_reg, cnt1_reg;

   logic             slot_free, grant0, grant1, grant_any, handoff;
   logic [WIDTH-1:0] op_a, op_b, b_inv, add_sum;
   logic             op_sub, add_ovf;

   // The buffer can take a new result when it is empty, or when it is being drained in the same cycle.
   always_comb begin
      slot_free = (state_reg == EMPTY) || res_ready;
      grant0    = 1'b0;
      grant1    = 1'b0;
      if (!rst && slot_free) begin
         if (req0_valid && (!req1_valid || !rr_reg))
            grant0 = 1'b1;
         else if (req1_valid)
            grant1 = 1'b1;
      end
   end

   assign grant_any = grant0 | grant1;
   assign handoff   = (state_reg == FULL) && res_ready;

   assign op_a   = grant1 ? req1_a   : req0_a;
   assign op_b   = grant1 ? req1_b   : req0_b;
   assign op_sub = grant1 ? req1_sub : req0_sub;
   assign b_inv  = op_b ^ {WIDTH{op_sub}};

   adder_64bit u_adder (
      .a    (op_a),
      .b    (b_inv),
      .c_in (op_sub),
      .sum  (add_sum),
      .ovf  (add_ovf)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY:   if (grant_any) state_next = FULL;
         FULL:    if (res_ready && !grant_any) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= EMPTY;
         rr_reg    <= 1'b0;
         sum_reg   <= '0;
         ovf_reg   <= 1'b0;
         id_reg    <= 1'b0;
         cnt0_reg  <= '0;
         cnt1_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (grant_any) begin
            rr_reg  <= grant0;  // priority passes to the requester that lost
            sum_reg <= add_sum;
            ovf_reg <= add_ovf;
            id_reg  <= grant1;
         end
         if (handoff && !id_reg) cnt0_reg <= cnt0_reg + 1'b1;
         if (handoff && id_reg)  cnt1_reg <= cnt1_reg + 1'b1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign res_valid  = (state_reg == FULL);
   assign res_sum    = sum_reg;
   assign res_ovf    = ovf_reg;
   assign res_id     = id_reg;
   assign cnt0       = cnt0_reg;
   assign cnt1       = cnt1_reg;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter.
// Accepted ops go into a scoreboard of expected results, and every result handoff is checked against it.

module tb_adder_share_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_sub;
   logic [63:0] req0_a, req0_b;
   logic        req1_valid, req1_ready, req1_sub;
   logic [63:0] req1_a, req1_b;
   logic        res_valid, res_ready, res_ovf, res_id;
   logic [63:0] res_sum;
   logic [15:0] cnt0, cnt1;

   typedef struct {
      logic [63:0] sum;
      logic        ovf;
      logic        id;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic        m_full = 1'b0;
   logic        m_rr = 1'b0;
   logic [15:0] m_cnt0 = '0, m_cnt1 = '0;
   logic [63:0] hold_sum;
   logic        hold_id;

   always #5 clk = ~clk;

   adder_share_arbiter #(.WIDTH(64), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
      .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_ovf(res_ovf), .res_id(res_id),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Two's-complement reference: subtraction overflows when the operand signs differ and the result sign differs from A.
   function automatic exp_t calc(input logic [63:0] a, input logic [63:0] b, input logic sub, input logic id);
      exp_t e;
      e.sum = sub ? a - b : a + b;
      e.ovf = sub ? ((a[63] != b[63]) && (e.sum[63] != a[63]))
                  : ((a[63] == b[63]) && (e.sum[63] != a[63]));
      e.id  = id;
      return e;
   endfunction

   // One clock cycle: check at the falling edge, update the model, then return just after the next rising edge.
   task automatic tick();
      logic free, g0, g1;
      exp_t e;
      @(negedge clk);
      free = !m_full || res_ready;
      g0 = !rst && free && req0_valid && (!req1_valid || !m_rr);
      g1 = !rst && free && req1_valid && (!req0_valid || m_rr);
      chk("req0_ready", {63'd0, req0_ready}, {63'd0, g0});
      chk("req1_ready", {63'd0, req1_ready}, {63'd0, g1});
      chk("res_valid", {63'd0, res_valid}, {63'd0, m_full});
      chk("cnt0", {48'd0, cnt0}, {48'd0, m_cnt0});
      chk("cnt1", {48'd0, cnt1}, {48'd0, m_cnt1});
      if (rst) begin
         sb.delete();
         m_full = 1'b0; m_rr = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
      end else begin
         if (m_full && res_ready) begin
            if (sb.size() == 0) begin
               chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("res_sum", res_sum, e.sum);
               chk("res_ovf", {63'd0, res_ovf}, {63'd0, e.ovf});
               chk("res_id", {63'd0, res_id}, {63'd0, e.id});
               if (e.id) m_cnt1 = m_cnt1 + 16'd1; else m_cnt0 = m_cnt0 + 16'd1;
            end
         end
         if (g0) sb.push_back(calc(req0_a, req0_b, req0_sub, 1'b0));
         if (g1) sb.push_back(calc(req1_a, req1_b, req1_sub, 1'b1));
         if (g0 || g1) begin
            m_full = 1'b1;
            m_rr   = g0;
         end else if (res_ready) begin
            m_full = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; res_ready = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
      @(posedge clk); #1;
      tick(); tick();
      rst = 1'b0;
      tick(); tick();
      chk("idle_sum", res_sum, 64'd0);
      chk("idle_ovf", {63'd0, res_ovf}, 64'd0);
      chk("idle_id", {63'd0, res_id}, 64'd0);

      // Single add: 0x7FFF..FF + 1 overflows into the sign bit.
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 64'h7FFF_FFFF_FFFF_FFFF; req0_b = 64'd1; req0_sub = 1'b0;
      tick();
      req0_valid = 1'b0;
      chk("add_valid", {63'd0, res_valid}, 64'd1);
      chk("add_sum", res_sum, 64'h8000_0000_0000_0000);
      chk("add_ovf", {63'd0, res_ovf}, 64'd1);
      tick();
      chk("add_cnt0", {48'd0, cnt0}, 64'd1);

      // Subtraction edge cases.
      req1_valid = 1'b1; req1_a = 64'd0; req1_b = 64'h8000_0000_0000_0000; req1_sub = 1'b1;
      tick();
      req1_valid = 1'b0;
      chk("sub_min_sum", res_sum, 64'h8000_0000_0000_0000);
      chk("sub_min_ovf", {63'd0, res_ovf}, 64'd1);
      chk("sub_min_id", {63'd0, res_id}, 64'd1);
      tick();
      req1_valid = 1'b1; req1_a = 64'd5; req1_b = 64'd7; req1_sub = 1'b1;
      tick();
      req1_valid = 1'b0;
      chk("sub_neg_sum", res_sum, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub_neg_ovf", {63'd0, res_ovf}, 64'd0);
      tick();

      // Round-robin: both requesters valid for six cycles.
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; req0_sub = $urandom_range(0, 1);
         req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; req1_sub = $urandom_range(0, 1);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      chk("rr_cnt0", {48'd0, cnt0}, 64'd4);
      chk("rr_cnt1", {48'd0, cnt1}, 64'd5);

      // Backpressure with both requesters valid, then a drain and refill in the same cycle.
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 64'd100; req0_b = 64'd1; req0_sub = 1'b0;
      req1_a = 64'd200; req1_b = 64'd3; req1_sub = 1'b1;
      tick();
      res_ready = 1'b0;
      hold_sum = res_sum; hold_id = res_id;
      chk("bp_first_sum", res_sum, 64'd101);
      for (int i = 0; i < 4; i++) tick();
      chk("bp_sum_stable", res_sum, hold_sum);
      chk("bp_id_stable", {63'd0, res_id}, {63'd0, hold_id});
      res_ready = 1'b1;
      tick();
      chk("bp_refill_id", {63'd0, res_id}, 64'd1);
      chk("bp_refill_sum", res_sum, 64'd197);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(); tick();

      // Reset while a result is held and res_ready is high.
      req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd9; req0_sub = 1'b0;
      tick();
      req0_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_valid", {63'd0, res_valid}, 64'd0);
      chk("rst_cnt0", {48'd0, cnt0}, 64'd0);
      chk("rst_sum", res_sum, 64'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 64'd1; req0_b = 64'd2; req0_sub = 1'b0;
      req1_a = 64'd3; req1_b = 64'd4; req1_sub = 1'b0;
      tick();
      chk("rst_rr_id", {63'd0, res_id}, 64'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(); tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
